shift_ex_stage: RTL and testbench

Two-entry pipelined execute stage for MIPS R-type shift instructions (sll, srl, sra, sllv, srlv, srav). It accepts decoded instruction fields from the decode stage over a valid/ready handshake and registers them. It derives the shifter controls, drives the team's combinational `shift` barrel shifter, and registers the result toward writeback with its own valid/ready handshake. It sits between instruction decode and the writeback/forwarding logic.

---
 rtl/shift_ex_stage_pkg.sv | 91 +++++++++
 rtl/shift_ex_stage_shift.sv | 23 ++
 rtl/shift_ex_stage.sv | 96 +++++++++
 tb/tb_shift_ex_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_ex_stage_pkg.sv
// Shared definitions for the two-entry shift execute stage: funct codes,
// stage payload types and the decode/retire helpers.
package shift_ex_stage_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  typedef struct packed {
    logic [31:0] rt;
    logic [4:0]  amount;
    logic        right;
    logic        arith;
    logic [4:0]  rd;
    logic        illegal;
  } s1_payload_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wreg;
    logic        illegal;
  } s2_payload_t;

  // Only the low five bits of rs ever steer a variable shift.
  function automatic s1_payload_t decode_shift(
    input logic [5:0]  funct,
    input logic [4:0]  shamt,
    input logic [4:0]  rs_amt,
    input logic [31:0] rt,
    input logic [4:0]  rd
  );
    s1_payload_t p;
    p.rt      = rt;
    p.rd      = rd;
    p.amount  = shamt;
    p.right   = 1'b0;
    p.arith   = 1'b0;
    p.illegal = 1'b0;
    case (funct)
      FUNCT_SLL: begin
        p.amount = shamt;
      end
      FUNCT_SRL: begin
        p.right = 1'b1;
      end
      FUNCT_SRA: begin
        p.right = 1'b1;
        p.arith = 1'b1;
      end
      FUNCT_SLLV: begin
        p.amount = rs_amt;
      end
      FUNCT_SRLV: begin
        p.amount = rs_amt;
        p.right  = 1'b1;
      end
      FUNCT_SRAV: begin
        p.amount = rs_amt;
        p.right  = 1'b1;
        p.arith  = 1'b1;
      end
      default: begin
        p.illegal = 1'b1;
      end
    endcase
    return p;
  endfunction

  // Illegal instructions must never write the register file or leak data.
  function automatic s2_payload_t retire_shift(
    input s1_payload_t s1,
    input logic [31:0] sh
  );
    s2_payload_t p;
    p.rd      = s1.rd;
    p.illegal = s1.illegal;
    if (s1.illegal) begin
      p.result = 32'h0000_0000;
      p.wreg   = 1'b0;
    end else begin
      p.result = sh;
      p.wreg   = (s1.rd != 5'd0);
    end
    return p;
  endfunction

endpackage

// File: rtl/shift_ex_stage_shift.sv
// Combinational 32-bit barrel shifter shared across execute stages
// (module name "shift").
module shift (
  input  logic [31:0] d,
  input  logic [4:0]  sa,
  input  logic        right,
  input  logic        arith,
  output logic [31:0] sh
);

  // Left shift, logical right shift, or sign-filling right shift.
  always_comb begin
    sh = 32'h0000_0000;
    if (!right) begin
      sh = d << sa;
    end else if (arith) begin
      sh = $signed(d) >>> sa;
    end else begin
      sh = d >> sa;
    end
  end

endmodule

// File: rtl/shift_ex_stage.sv
// Two-entry execute stage for R-type shifts: decode into S1, shift between
// S1 and S2, registered result toward writeback with valid/ready on both sides.
module shift_ex_stage
  import shift_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_shamt,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wreg,
  output logic        out_illegal
);

  logic        s1_valid_r;
  logic        s2_valid_r;
  s1_payload_t s1_r;
  s2_payload_t s2_r;
  s1_payload_t s1_next_s;
  s2_payload_t s2_next_s;
  logic [31:0] sh_s;
  logic        s2_free_s;
  logic        s1_adv_s;
  logic        in_xfer_s;
  logic        unused_rs_s;

  assign unused_rs_s = ^in_rs[31:5];

  // in_ready depends only on occupancy and out_ready, never on in_valid.
  assign s2_free_s = ~s2_valid_r | out_ready;
  assign s1_adv_s  = s1_valid_r & s2_free_s;
  assign in_ready  = ~s1_valid_r | s2_free_s;
  assign in_xfer_s = in_valid & in_ready;

  assign s1_next_s = decode_shift(in_funct, in_shamt, in_rs[4:0], in_rt, in_rd);

  shift u_shift (
    .d     (s1_r.rt),
    .sa    (s1_r.amount),
    .right (s1_r.right),
    .arith (s1_r.arith),
    .sh    (sh_s)
  );

  assign s2_next_s = retire_shift(s1_r, sh_s);

  // S1: capture on input transfer, empty when its entry moves on.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1_valid_r <= 1'b0;
      s1_r       <= '0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (in_xfer_s) begin
      s1_valid_r <= 1'b1;
      s1_r       <= s1_next_s;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // S2: load from S1 when free, otherwise hold until writeback consumes it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s2_valid_r <= 1'b0;
      s2_r       <= '0;
    end else if (flush) begin
      s2_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      s2_valid_r <= 1'b1;
      s2_r       <= s2_next_s;
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  assign out_valid   = s2_valid_r;
  assign out_result  = s2_r.result;
  assign out_rd      = s2_r.rd;
  assign out_wreg    = s2_r.wreg;
  assign out_illegal = s2_r.illegal;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Self-checking bench for shift_ex_stage: directed vector table, hand-written
// backpressure/flush/reset sequences, then randomized traffic against a FIFO model.
module tb_shift_ex_stage;

  logic        clk = 1'b0;
  logic        clrn, flush, in_valid, in_ready, out_valid, out_ready, out_wreg, out_illegal;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt, in_rd, out_rd;
  logic [31:0] in_rs, in_rt, out_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_ex_stage dut (
    .clk(clk), .clrn(clrn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wreg(out_wreg), .out_illegal(out_illegal)
  );

  typedef struct { logic [31:0] res; logic [4:0] rd; logic wreg; logic ill; } exp_t;
  typedef struct { exp_t e; int acc; } ent_t;
  typedef struct {
    logic [5:0] f; logic [4:0] sh; logic [31:0] rs; logic [31:0] rt; logic [4:0] rd;
    logic [31:0] res; logic wreg; logic ill;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from the instruction definitions.
  function automatic exp_t model(input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
    exp_t e;
    logic [31:0] v;
    v = rs & 32'd31;
    e.rd = rd; e.ill = 1'b0; e.res = 32'h0;
    case (f)
      6'd0: e.res = rt << sh;
      6'd2: e.res = rt >> sh;
      6'd3: e.res = rt[31] ? ~((~rt) >> sh) : (rt >> sh);
      6'd4: e.res = rt << v;
      6'd6: e.res = rt >> v;
      6'd7: e.res = rt[31] ? ~((~rt) >> v) : (rt >> v);
      default: e.ill = 1'b1;
    endcase
    e.wreg = !e.ill && (rd != 5'd0);
    return e;
  endfunction

  task automatic drive(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] rd);
    in_funct = f; in_shamt = sh; in_rs = rs; in_rt = rt; in_rd = rd;
  endtask

  // Present one instruction and wait (bounded) until it is accepted.
  task automatic send(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [4:0] rd);
    logic acc;
    drive(f, sh, rs, rt, rd);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  vec_t vt[10];
  logic [5:0] legal_f[6];
  ent_t q[$];

  initial begin
    int idx, got, accepts, edge_n;
    logic ev, eir, ix, ox, hold;
    ent_t ne;

    legal_f = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
    vt[0] = '{6'h00, 5'd31, 32'h0000_0000, 32'h0000_0001, 5'd5,  32'h8000_0000, 1'b1, 1'b0};
    vt[1] = '{6'h07, 5'd0,  32'h0000_0024, 32'hF000_0000, 5'd3,  32'hFF00_0000, 1'b1, 1'b0};
    vt[2] = '{6'h06, 5'd0,  32'h0000_0024, 32'hF000_0000, 5'd3,  32'h0F00_0000, 1'b1, 1'b0};
    vt[3] = '{6'h02, 5'd0,  32'h0000_0000, 32'h8000_0001, 5'd0,  32'h8000_0001, 1'b0, 1'b0};
    vt[4] = '{6'h20, 5'd3,  32'h0000_0000, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 1'b0, 1'b1};
    vt[5] = '{6'h04, 5'd0,  32'hFFFF_FFE3, 32'h0000_000F, 5'd31, 32'h0000_0078, 1'b1, 1'b0};
    vt[6] = '{6'h03, 5'd31, 32'h0000_0000, 32'h8000_0000, 5'd1,  32'hFFFF_FFFF, 1'b1, 1'b0};
    vt[7] = '{6'h02, 5'd31, 32'h0000_0000, 32'h8000_0000, 5'd2,  32'h0000_0001, 1'b1, 1'b0};
    vt[8] = '{6'h03, 5'd4,  32'h0000_0000, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 1'b1, 1'b0};
    vt[9] = '{6'h05, 5'd2,  32'h0000_0001, 32'h1234_5678, 5'd9,  32'h0000_0000, 1'b0, 1'b1};

    clrn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    #1;
    chk("rst_in_ready", in_ready, 1); chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0); chk("rst_rd", out_rd, 0);
    chk("rst_wreg", out_wreg, 0);     chk("rst_illegal", out_illegal, 0);
    @(posedge clk); #1;
    clrn = 1'b1;

    // Directed vectors, one at a time, with the two-edge latency checked.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].f, vt[i].sh, vt[i].rs, vt[i].rt, vt[i].rd);
      in_valid = 1'b1;
      #1 chk("vec_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("vec_latency", out_valid, 0);
      @(posedge clk); #1;
      chk("vec_out_valid", out_valid, 1);
      chk("vec_result", out_result, vt[i].res);
      chk("vec_rd", out_rd, vt[i].rd);
      chk("vec_wreg", out_wreg, vt[i].wreg);
      chk("vec_illegal", out_illegal, vt[i].ill);
    end
    @(posedge clk); #1;

    // Backpressure: four sll by 1 with writeback stalled for three cycles.
    idx = 0; got = 0; accepts = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      out_ready = (c >= 3);
      in_valid = (idx < 4);
      drive(6'd0, 5'd1, 32'd0, idx + 1, 5'(idx + 1));
      #1;
      if (accepts == 2 && !out_ready) chk("bp_in_ready_full", in_ready, 0);
      if (out_valid && out_ready) begin
        chk("bp_order", out_result, 2 * (got + 1));
        got++;
      end
      if (in_valid && in_ready) begin
        idx++; accepts++;
      end
      @(posedge clk); #1;
    end
    chk("bp_count", got, 4);
    in_valid = 1'b0;

    // Flush with two in flight; the instruction offered alongside is dropped.
    out_ready = 1'b0;
    send(6'd0, 5'd2, 32'd0, 32'd3, 5'd1);
    send(6'd2, 5'd4, 32'd0, 32'h100, 5'd2);
    chk("fl_full_valid", out_valid, 1);
    chk("fl_full_in_ready", in_ready, 0);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    drive(6'd0, 5'd1, 32'd0, 32'd7, 5'd6);
    #1 chk("fl_in_ready_kept", in_ready, 1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("fl_discard", out_valid, 0);
    send(6'd3, 5'd1, 32'd0, 32'h8000_0000, 5'd3);
    @(posedge clk); #1;
    chk("fl_after_valid", out_valid, 1);
    chk("fl_after_result", out_result, 32'hC000_0000);
    @(posedge clk); #1;

    // Asynchronous reset with two in flight.
    out_ready = 1'b0;
    send(6'd0, 5'd4, 32'd0, 32'd1, 5'd8);
    send(6'd2, 5'd1, 32'd0, 32'd8, 5'd9);
    chk("rs_full_valid", out_valid, 1);
    #2 clrn = 1'b0;
    #1;
    chk("rs_out_valid", out_valid, 0); chk("rs_result", out_result, 0);
    chk("rs_rd", out_rd, 0);           chk("rs_wreg", out_wreg, 0);
    chk("rs_illegal", out_illegal, 0); chk("rs_in_ready", in_ready, 1);
    #1 clrn = 1'b1;
    @(posedge clk); #1;
    chk("rs_stay_empty", out_valid, 0);
    @(posedge clk); #1;
    chk("rs_stay_empty2", out_valid, 0);

    // Randomized traffic against the in-order queue model.
    edge_n = 0; hold = 1'b0; q.delete();
    for (int c = 0; c < 3000; c++) begin
      ev = (q.size() > 0) && (edge_n - q[0].acc >= 1);
      chk("rnd_out_valid", out_valid, ev);
      if (ev) begin
        chk("rnd_result", out_result, q[0].e.res);
        chk("rnd_rd", out_rd, q[0].e.rd);
        chk("rnd_wreg", out_wreg, q[0].e.wreg);
        chk("rnd_illegal", out_illegal, q[0].e.ill);
      end
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) < 6) in_funct = legal_f[$urandom_range(0, 5)];
        else in_funct = 6'($urandom_range(0, 63));
        in_shamt = 5'($urandom_range(0, 31));
        in_rs = $urandom; in_rt = $urandom;
        in_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      #1;
      eir = (q.size() < 2) || out_ready;
      chk("rnd_in_ready", in_ready, eir);
      ix = in_valid && eir;
      ox = ev && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (ox) void'(q.pop_front());
        if (ix) begin
          ne.e = model(in_funct, in_shamt, in_rs, in_rt, in_rd);
          ne.acc = edge_n + 1;
          q.push_back(ne);
        end
      end
      hold = in_valid && !ix && !flush;
      @(posedge clk); #1;
      edge_n++;
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
